// File: rtl/uart_cmd_framer.sv
// Assembles 5-byte command frames (header, cmd, data_hi, data_lo, checksum) from a UART
// byte stream, checks the inverted-sum checksum, enforces an inter-byte timeout.
module uart_cmd_framer #(
   parameter logic [7:0]  HDR    = 8'hA5,
   parameter int unsigned TO_CYC = 500000,
   parameter int unsigned TO_W   = $clog2(TO_CYC)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_rdy,
   input  logic [7:0]  rx_data,
   output logic        clr_rx_rdy,
   input  logic        clr_cmd_rdy,
   output logic        cmd_rdy,
   output logic [7:0]  cmd,
   output logic [15:0] data,
   output logic        frame_err,
   output logic        to_err,
   output logic        ovr_err
);

   typedef enum logic [2:0] {S_HDR, S_CMD, S_DHI, S_DLO, S_CHK} state_t;

   state_t          r_state;
   state_t          w_nxt;
   logic [TO_W-1:0] r_to_cnt;
   logic [7:0]      r_cmd_tmp;
   logic [7:0]      r_dhi_tmp;
   logic [7:0]      r_dlo_tmp;
   logic            r_cmd_rdy;
   logic [7:0]      r_cmd;
   logic [15:0]     r_data;
   logic            r_frame_err;
   logic            r_to_err;
   logic            r_ovr_err;

   logic            w_accept;
   logic [7:0]      w_sum;
   logic            w_pass;
   logic            w_fail;
   logic            w_timeout;

   assign w_accept   = rx_rdy;
   assign clr_rx_rdy = w_accept;
   assign w_sum      = r_cmd_tmp + r_dhi_tmp + r_dlo_tmp;

   always_comb begin
      w_nxt     = r_state;
      w_pass    = 1'b0;
      w_fail    = 1'b0;
      w_timeout = (r_state != S_HDR) && !w_accept && (r_to_cnt == TO_W'(TO_CYC - 1));
      if (w_timeout) begin
         w_nxt = S_HDR;
      end else if (w_accept) begin
         unique case (r_state)
            S_HDR:   if (rx_data == HDR) w_nxt = S_CMD;
            S_CMD:   w_nxt = S_DHI;
            S_DHI:   w_nxt = S_DLO;
            S_DLO:   w_nxt = S_CHK;
            S_CHK: begin
               w_nxt  = S_HDR;
               w_pass = (rx_data == ~w_sum);
               w_fail = (rx_data != ~w_sum);
            end
            default: w_nxt = S_HDR;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_HDR;
         r_to_cnt    <= '0;
         r_cmd_tmp   <= '0;
         r_dhi_tmp   <= '0;
         r_dlo_tmp   <= '0;
         r_cmd_rdy   <= 1'b0;
         r_cmd       <= '0;
         r_data      <= '0;
         r_frame_err <= 1'b0;
         r_to_err    <= 1'b0;
         r_ovr_err   <= 1'b0;
      end else begin
         r_state <= w_nxt;
         // Counter only runs mid-frame; any consumed byte restarts the gap measurement.
         if (r_state == S_HDR || w_accept || w_timeout) r_to_cnt <= '0;
         else                                           r_to_cnt <= r_to_cnt + TO_W'(1);
         if (w_accept && r_state == S_CMD) r_cmd_tmp <= rx_data;
         if (w_accept && r_state == S_DHI) r_dhi_tmp <= rx_data;
         if (w_accept && r_state == S_DLO) r_dlo_tmp <= rx_data;
         if (w_pass) begin
            r_cmd     <= r_cmd_tmp;
            r_data    <= {r_dhi_tmp, r_dlo_tmp};
            r_cmd_rdy <= 1'b1;
         end else if (clr_cmd_rdy) begin
            r_cmd_rdy <= 1'b0;
         end
         r_frame_err <= w_fail;
         r_to_err    <= w_timeout;
         r_ovr_err   <= w_pass && r_cmd_rdy && !clr_cmd_rdy;
      end
   end

   assign cmd_rdy   = r_cmd_rdy;
   assign cmd       = r_cmd;
   assign data      = r_data;
   assign frame_err = r_frame_err;
   assign to_err    = r_to_err;
   assign ovr_err   = r_ovr_err;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed self-checking bench for uart_cmd_framer with a shortened timeout (TO_CYC=100).
module tb_uart_cmd_framer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_rdy = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        clr_rx_rdy;
   logic        clr_cmd_rdy = 1'b0;
   logic        cmd_rdy;
   logic [7:0]  cmd;
   logic [15:0] data;
   logic        frame_err;
   logic        to_err;
   logic        ovr_err;

   int n_vec  = 0;
   int n_fail = 0;
   int n_fe = 0, n_te = 0, n_oe = 0;

   uart_cmd_framer #(.HDR(8'hA5), .TO_CYC(100)) dut (
      .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
      .clr_rx_rdy(clr_rx_rdy), .clr_cmd_rdy(clr_cmd_rdy), .cmd_rdy(cmd_rdy),
      .cmd(cmd), .data(data), .frame_err(frame_err), .to_err(to_err), .ovr_err(ovr_err)
   );

   always #5 clk = ~clk;

   // Cycle-accurate pulse counters: each high cycle of an error output counts once.
   always @(posedge clk) begin
      if (frame_err) n_fe++;
      if (to_err)    n_te++;
      if (ovr_err)   n_oe++;
   end

   // Called at a negedge; presents one byte for exactly one clock and returns at the next negedge.
   task automatic send(input logic [7:0] b);
      rx_rdy  = 1'b1;
      rx_data = b;
      #1;
      n_vec++;
      if (clr_rx_rdy !== 1'b1) begin n_fail++; $display("FAIL clr_rx_rdy byte=%h got=%b exp=1", b, clr_rx_rdy); end
      @(negedge clk);
      rx_rdy  = 1'b0;
      rx_data = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic frame(input logic [7:0] c, input logic [7:0] dh, input logic [7:0] dl, input logic [7:0] k);
      send(8'hA5); send(c); send(dh); send(dl); send(k);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if ({cmd_rdy, cmd, data, frame_err, to_err, ovr_err} !== 28'd0) begin
         n_fail++; $display("FAIL reset_outputs got=%h exp=0", {cmd_rdy, cmd, data, frame_err, to_err, ovr_err});
      end
      n_vec++;
      if (clr_rx_rdy !== 1'b0) begin n_fail++; $display("FAIL idle_clr_rx_rdy got=%b exp=0", clr_rx_rdy); end
   endtask

   task automatic test_nominal();
      int fe0, te0, oe0;
      do_reset();
      fe0 = n_fe; te0 = n_te; oe0 = n_oe;
      send(8'hA5); send(8'h10); send(8'h12); send(8'h34);
      n_vec++;
      if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL nom_early_rdy got=%b exp=0", cmd_rdy); end
      send(8'hA9);
      n_vec++;
      if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL nom_rdy got=%b exp=1", cmd_rdy); end
      n_vec++;
      if (cmd !== 8'h10 || data !== 16'h1234) begin n_fail++; $display("FAIL nom_payload got=%h/%h exp=10/1234", cmd, data); end
      idle(3);
      n_vec++;
      if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL nom_rdy_hold got=%b exp=1", cmd_rdy); end
      clr_cmd_rdy = 1'b1;
      idle(1);
      clr_cmd_rdy = 1'b0;
      n_vec++;
      if (cmd_rdy !== 1'b0 || cmd !== 8'h10) begin n_fail++; $display("FAIL nom_clear got=%b/%h exp=0/10", cmd_rdy, cmd); end
      idle(1);
      n_vec++;
      if (n_fe != fe0 || n_te != te0 || n_oe != oe0) begin
         n_fail++; $display("FAIL nom_no_err got=%0d/%0d/%0d exp=0/0/0", n_fe - fe0, n_te - te0, n_oe - oe0);
      end
   endtask

   task automatic test_bad_checksum();
      int fe0;
      do_reset();
      fe0 = n_fe;
      frame(8'h10, 8'h12, 8'h34, 8'h00);
      n_vec++;
      if (frame_err !== 1'b1 || cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL bad_chk got fe=%b rdy=%b exp 1/0", frame_err, cmd_rdy); end
      idle(1);
      n_vec++;
      if (frame_err !== 1'b0 || cmd !== 8'h00 || data !== 16'h0000) begin
         n_fail++; $display("FAIL bad_chk_hold got fe=%b %h/%h exp 0 00/0000", frame_err, cmd, data);
      end
      frame(8'h01, 8'h00, 8'h00, 8'hFE);
      n_vec++;
      if (cmd_rdy !== 1'b1 || cmd !== 8'h01 || data !== 16'h0000) begin
         n_fail++; $display("FAIL recover got=%b %h/%h exp=1 01/0000", cmd_rdy, cmd, data);
      end
      idle(2);
      n_vec++;
      if (n_fe - fe0 != 1) begin n_fail++; $display("FAIL bad_chk_pulses got=%0d exp=1", n_fe - fe0); end
   endtask

   task automatic test_garbage();
      int fe0, te0, oe0;
      do_reset();
      fe0 = n_fe; te0 = n_te; oe0 = n_oe;
      send(8'h00); send(8'hFF); send(8'h5A);
      frame(8'h20, 8'hAB, 8'hCD, 8'h67);
      n_vec++;
      if (cmd_rdy !== 1'b1 || cmd !== 8'h20 || data !== 16'hABCD) begin
         n_fail++; $display("FAIL garbage got=%b %h/%h exp=1 20/abcd", cmd_rdy, cmd, data);
      end
      idle(2);
      n_vec++;
      if (n_fe != fe0 || n_te != te0 || n_oe != oe0) begin
         n_fail++; $display("FAIL garbage_err got=%0d/%0d/%0d exp=0/0/0", n_fe - fe0, n_te - te0, n_oe - oe0);
      end
   endtask

   task automatic test_timeout();
      int te0;
      do_reset();
      te0 = n_te;
      send(8'hA5); send(8'h10);
      idle(99);
      n_vec++;
      if (to_err !== 1'b0) begin n_fail++; $display("FAIL to_early got=%b exp=0", to_err); end
      idle(1);
      n_vec++;
      if (to_err !== 1'b1) begin n_fail++; $display("FAIL to_pulse got=%b exp=1", to_err); end
      idle(1);
      n_vec++;
      if (to_err !== 1'b0 || n_te - te0 != 1 || cmd_rdy !== 1'b0) begin
         n_fail++; $display("FAIL to_width got=%b cnt=%0d rdy=%b exp 0/1/0", to_err, n_te - te0, cmd_rdy);
      end
      frame(8'h10, 8'h12, 8'h34, 8'hA9);
      n_vec++;
      if (cmd_rdy !== 1'b1 || cmd !== 8'h10 || data !== 16'h1234) begin
         n_fail++; $display("FAIL to_recover got=%b %h/%h exp=1 10/1234", cmd_rdy, cmd, data);
      end
      clr_cmd_rdy = 1'b1; idle(1); clr_cmd_rdy = 1'b0;
      // 98-cycle gaps, and one 99-cycle gap whose byte lands on the terminal count
      send(8'hA5); send(8'h20); idle(98);
      send(8'hAB); idle(98);
      send(8'hCD); idle(99);
      send(8'h67);
      n_vec++;
      if (cmd_rdy !== 1'b1 || cmd !== 8'h20 || data !== 16'hABCD) begin
         n_fail++; $display("FAIL gap_frame got=%b %h/%h exp=1 20/abcd", cmd_rdy, cmd, data);
      end
      idle(2);
      n_vec++;
      if (n_te - te0 != 1) begin n_fail++; $display("FAIL gap_no_to got=%0d exp=1", n_te - te0); end
   endtask

   task automatic test_back_to_back();
      int oe0;
      do_reset();
      oe0 = n_oe;
      frame(8'h10, 8'h12, 8'h34, 8'hA9);
      frame(8'h01, 8'h00, 8'h00, 8'hFE);
      n_vec++;
      if (ovr_err !== 1'b1 || cmd_rdy !== 1'b1 || cmd !== 8'h01 || data !== 16'h0000) begin
         n_fail++; $display("FAIL overrun got ovr=%b rdy=%b %h/%h exp 1 1 01/0000", ovr_err, cmd_rdy, cmd, data);
      end
      idle(2);
      n_vec++;
      if (ovr_err !== 1'b0 || n_oe - oe0 != 1) begin n_fail++; $display("FAIL ovr_width got=%b cnt=%0d exp 0/1", ovr_err, n_oe - oe0); end
      clr_cmd_rdy = 1'b1; idle(1); clr_cmd_rdy = 1'b0;
      oe0 = n_oe;
      frame(8'h20, 8'hAB, 8'hCD, 8'h67);
      send(8'hA5); send(8'h10); send(8'h12); send(8'h34);
      clr_cmd_rdy = 1'b1;
      send(8'hA9);
      clr_cmd_rdy = 1'b0;
      n_vec++;
      if (cmd_rdy !== 1'b1 || cmd !== 8'h10 || data !== 16'h1234 || ovr_err !== 1'b0) begin
         n_fail++; $display("FAIL set_wins got rdy=%b %h/%h ovr=%b exp 1 10/1234 0", cmd_rdy, cmd, data, ovr_err);
      end
      idle(2);
      n_vec++;
      if (n_oe != oe0) begin n_fail++; $display("FAIL set_wins_ovr got=%0d exp=0", n_oe - oe0); end
   endtask

   task automatic test_reset_mid_frame();
      int fe0, te0, oe0;
      do_reset();
      send(8'hA5); send(8'h10); send(8'h12);
      #2 rst_n = 1'b0;
      #3 rst_n = 1'b1;
      @(negedge clk);
      fe0 = n_fe; te0 = n_te; oe0 = n_oe;
      send(8'h34); send(8'hA9);
      idle(2);
      n_vec++;
      if (cmd_rdy !== 1'b0 || cmd !== 8'h00 || data !== 16'h0000) begin
         n_fail++; $display("FAIL mid_reset got=%b %h/%h exp=0 00/0000", cmd_rdy, cmd, data);
      end
      n_vec++;
      if (n_fe != fe0 || n_te != te0 || n_oe != oe0) begin
         n_fail++; $display("FAIL mid_reset_err got=%0d/%0d/%0d exp=0/0/0", n_fe - fe0, n_te - te0, n_oe - oe0);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_bad_checksum();
      test_garbage();
      test_timeout();
      test_back_to_back();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_cmd_framer.md
Name: uart_cmd_framer

Overview:
- Sits directly downstream of the UART receiver and consumes its rdy/rx_data byte stream, driving the receiver's clr_rdy.
- Assembles 5-byte command frames: header, cmd, data_hi, data_lo, checksum.
- Validates the checksum and enforces an inter-byte timeout.
- Presents validated {cmd, data} to the control logic with a ready/clear handshake.

Parameters:
HDR  8'hA5  frame header byte
TO_CYC  500000  inter-byte timeout in clk cycles (10 ms at 50 MHz); min 4
TO_W  $clog2(TO_CYC)  timeout counter width (derived)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_rdy  in  1  byte-ready level from UART receiver
rx_data  in  8  received byte, valid while rx_rdy=1
clr_rx_rdy  out  1  byte-consume strobe to receiver clr_rdy (combinational)
clr_cmd_rdy  in  1  consumer acknowledge, clears cmd_rdy
cmd_rdy  out  1  validated command held in cmd/data
cmd  out  8  command byte
data  out  16  {data_hi, data_lo}
frame_err  out  1  1-cycle pulse, checksum mismatch
to_err  out  1  1-cycle pulse, inter-byte timeout
ovr_err  out  1  1-cycle pulse, valid frame overwrote unacknowledged command

Behaviour:
- Reset (async, rst_n=0): state=HDR; cmd_rdy=0; cmd=0; data=0; frame_err=to_err=ovr_err=0; timeout counter=0; partial-frame regs=0. A reset mid-frame discards the frame.
- Accept rule: accept = rx_rdy, in every state. Block never stalls. clr_rx_rdy = accept, same cycle, so the receiver drops rdy on the next edge. A byte is consumed exactly once.
- FSM states: HDR, CMD, DHI, DLO, CHK. All transitions occur on accepted bytes except timeout.
  - HDR: byte==HDR -> CMD. Other bytes are discarded silently and the state stays HDR.
  - CMD: latch cmd_tmp -> DHI.
  - DHI: latch dhi_tmp -> DLO.
  - DLO: latch dlo_tmp -> CHK.
  - CHK: the byte is compared to expected = ~(cmd_tmp + dhi_tmp + dlo_tmp) mod 256 (8-bit wrap sum, then invert). Always -> HDR.
- HDR inside a frame is treated as payload. There is no resync.
- CHK pass:
  - At the accepting edge, cmd<=cmd_tmp and data<={dhi_tmp,dlo_tmp}.
  - cmd_rdy<=1, so cmd_rdy is high the cycle after the checksum byte's rx_rdy cycle.
  - If cmd_rdy was already 1 at that edge, ovr_err pulses, the outputs are overwritten and cmd_rdy stays 1.
- CHK fail: frame_err pulses for one cycle. cmd/data/cmd_rdy are unchanged.
- cmd_rdy clear: clr_cmd_rdy clears cmd_rdy. If clr_cmd_rdy coincides with a CHK pass, set wins: cmd_rdy=1 with the new data, and no ovr_err.
- Timeout counter:
  - Held at 0 in HDR.
  - In CMD..CHK it counts up each cycle with no accept. Any accept resets it to 0.
  - When the counter reaches TO_CYC-1 with no accept that cycle: state->HDR, to_err pulses, counter->0, partial frame discarded, outputs unchanged.
  - If an accept occurs on the terminal cycle, the byte is processed normally and no timeout fires.
- Error pulses are registered, high for exactly one cycle. They never coincide with each other for the same event.
- cmd/data change only on a CHK pass and otherwise hold their values.

Test Plan:
- Nominal frame: reset, send A5 10 12 34 A9 via rx_rdy pulses.
  - clr_rx_rdy asserts on each of the 5 rx_rdy cycles.
  - cmd_rdy=1 one cycle after the A9 byte, with cmd=0x10 and data=0x1234.
  - clr_cmd_rdy -> cmd_rdy=0 next cycle.
- Bad checksum: send A5 10 12 34 00 -> frame_err one-cycle pulse, cmd_rdy stays 0. Then send A5 01 00 00 FE -> cmd=0x01, data=0x0000.
- Garbage/leading bytes: send 00 FF 5A then A5 20 AB CD 67 -> the first three bytes are consumed with no state change. Final cmd=0x20, data=0xABCD, no errors.
- Timeout (TO_CYC=100): send A5 10, then idle 100 cycles -> to_err pulses on cycle 100 after the 0x10 byte. Then the full frame A5 10 12 34 A9 is accepted normally. A gap of 98 idle cycles between bytes produces no timeout.
- Overrun and simultaneous events:
  - Two valid frames with no clr_cmd_rdy -> ovr_err pulse, and the outputs hold the second frame.
  - Repeat with clr_cmd_rdy asserted on the second set edge -> cmd_rdy=1, no ovr_err.
- Reset mid-frame: send A5 10 12, pulse rst_n low, then send 34 A9 -> both bytes are discarded in HDR, with cmd_rdy=0 and no errors.
